// File: rtl/menlo_audio_pkg.sv
// Shared types and constants for the audio sample feeder.
// Nibble-to-PCM conversion helper lives here so the gain math has a single definition.
package menlo_audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_UNDERRUN = 2'd2
    } state_e;

    localparam int FRAME_LEN = 32;
    localparam logic [3:0] SILENCE_CODE = 4'd8;

    typedef logic signed [15:0] pcm_t;

    // Centre the unsigned nibble around the silence code, then scale up.
    function automatic pcm_t nibble_to_pcm(input logic [3:0] nib, input int shift);
        logic signed [4:0] centred;
        pcm_t              ext;
        centred = signed'({1'b0, nib}) - signed'({1'b0, SILENCE_CODE});
        ext     = pcm_t'(centred);
        return ext <<< shift;
    endfunction

endpackage

// File: rtl/menlo_sync_fifo.sv
// Single-clock FIFO with explicit occupancy; pop data is read combinationally from the head.
// Push into a full FIFO and pop from an empty FIFO are ignored; no write-to-read bypass.
module menlo_sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_dat_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_dat_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok, pop_ok;

    assign push_ok = push_i && (level_q != LW'(DEPTH));
    assign pop_ok  = pop_i && (level_q != '0);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push_ok && !pop_ok) begin
            level_d = level_q + LW'(1);
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign pop_dat_o = mem_q[rd_ptr_q];
    assign level_o   = level_q;

endmodule

// File: rtl/menlo_audio_sample_feeder.sv
// Buffers Gigatron audio nibbles and emits one signed PCM word per frame, re-priming after underrun.
// Output registered at the frame boundary; sample_ready drops only when the buffer is full.
module menlo_audio_sample_feeder #(
    parameter int FIFO_DEPTH  = 8,
    parameter int PRIME_LEVEL = 4,
    parameter int FRAME_LEN   = menlo_audio_pkg::FRAME_LEN,
    parameter int GAIN_SHIFT  = 12
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [3:0]         sample_in,
    input  logic               sample_valid,
    output logic               sample_ready,
    input  logic               mute,
    output logic signed [15:0] audio_out,
    output logic               frame_strobe,
    output logic [3:0]         fifo_level,
    output logic [7:0]         underrun_count
);

    import menlo_audio_pkg::*;

    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int CW = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   frame_cnt_q, frame_cnt_d;
    pcm_t            audio_q, audio_d;
    logic            strobe_q;
    logic [7:0]      urun_q, urun_d;
    logic            boundary;
    logic            push, pop;
    logic [3:0]      head_dat;
    logic [LW-1:0]   level;

    menlo_sync_fifo #(
        .WIDTH (4),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (push),
        .push_dat_i (sample_in),
        .pop_i      (pop),
        .pop_dat_o  (head_dat),
        .level_o    (level)
    );

    assign sample_ready = (level != LW'(FIFO_DEPTH));
    assign push         = sample_valid && sample_ready;
    assign boundary     = (frame_cnt_q == LAST_CNT);
    assign frame_cnt_d  = boundary ? '0 : frame_cnt_q + CW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            frame_cnt_q <= '0;
            audio_q     <= '0;
            strobe_q    <= 1'b0;
            urun_q      <= '0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            audio_q     <= audio_d;
            strobe_q    <= boundary;
            urun_q      <= urun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (boundary) begin
            case (state_q)
                ST_IDLE:     if (level >= LW'(PRIME_LEVEL)) state_d = ST_RUN;
                ST_RUN:      if (level == '0) state_d = ST_UNDERRUN;
                ST_UNDERRUN: state_d = ST_IDLE;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    // Mute only overrides the loaded value; the pop still happens so pacing is kept.
    always_comb begin
        pop     = 1'b0;
        audio_d = audio_q;
        urun_d  = urun_q;
        if (boundary) begin
            case (state_q)
                ST_IDLE: audio_d = '0;
                ST_RUN: begin
                    if (level == '0) begin
                        urun_d = (urun_q == 8'hFF) ? urun_q : urun_q + 8'd1;
                    end else begin
                        pop     = 1'b1;
                        audio_d = nibble_to_pcm(head_dat, GAIN_SHIFT);
                    end
                end
                default: audio_d = audio_q;
            endcase
            if (mute) begin
                audio_d = '0;
            end
        end
    end

    assign audio_out      = audio_q;
    assign frame_strobe   = strobe_q;
    assign fifo_level     = 4'(level);
    assign underrun_count = urun_q;

endmodule

// File: tb/tb_menlo_audio_sample_feeder.sv
// Directed bench for the audio sample feeder: priming, playback, underrun, full buffer, mute, reset.
module tb_menlo_audio_sample_feeder;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [3:0]         sample_in = 4'd0;
    logic               sample_valid = 1'b0;
    logic               mute = 1'b0;
    logic               sample_ready;
    logic signed [15:0] audio_out;
    logic               frame_strobe;
    logic [3:0]         fifo_level;
    logic [7:0]         underrun_count;

    int total = 0;
    int bad   = 0;
    int gap;

    always #5 clk = ~clk;

    menlo_audio_sample_feeder dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .mute           (mute),
        .audio_out      (audio_out),
        .frame_strobe   (frame_strobe),
        .fifo_level     (fifo_level),
        .underrun_count (underrun_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic next_frame(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!frame_strobe && cycles < 100);
        chk("strobe_seen", frame_strobe, 1);
    endtask

    task automatic push(input logic [3:0] nib, input int n);
        sample_valid = 1'b1;
        sample_in    = nib;
        repeat (n) tick();
        sample_valid = 1'b0;
    endtask

    initial begin
        logic signed [31:0] exp_seq [4];
        exp_seq[0] = -32768;
        exp_seq[1] = -16384;
        exp_seq[2] = 0;
        exp_seq[3] = 16384;

        // Reset state
        #12;
        chk("rst_audio", audio_out, 0);
        chk("rst_strobe", frame_strobe, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_urun", underrun_count, 0);
        chk("rst_ready", sample_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;

        // Prime with four full-scale samples
        push(4'd15, 4);
        next_frame(gap);
        chk("first_gap", gap + 4, 32);
        chk("prime_audio", audio_out, 0);
        chk("prime_level", fifo_level, 4);
        for (int i = 0; i < 4; i++) begin
            next_frame(gap);
            chk("run_gap", gap, 32);
            chk("run_audio", audio_out, 28672);
            chk("run_level", fifo_level, 3 - i);
        end
        next_frame(gap);
        chk("urun_hold", audio_out, 28672);
        chk("urun_cnt", underrun_count, 1);
        next_frame(gap);
        chk("urun_state_hold", audio_out, 28672);
        next_frame(gap);
        chk("back_idle", audio_out, 0);

        // Below prime level: stays idle
        push(4'd5, 3);
        next_frame(gap);
        chk("under_prime_audio", audio_out, 0);
        chk("under_prime_level", fifo_level, 3);
        next_frame(gap);
        chk("under_prime_audio2", audio_out, 0);
        chk("under_prime_level2", fifo_level, 3);

        // Start playback, then reset mid-frame with five queued
        push(4'd5, 2);
        next_frame(gap);
        chk("d_prime_audio", audio_out, 0);
        chk("d_prime_level", fifo_level, 5);
        next_frame(gap);
        chk("d_pop_audio", audio_out, -12288);
        chk("d_pop_level", fifo_level, 4);
        push(4'd5, 1);
        repeat (16) tick();
        chk("midframe_audio_stable", audio_out, -12288);
        chk("midframe_level", fifo_level, 5);
        reset_n = 1'b0;
        #2;
        chk("async_rst_audio", audio_out, 0);
        chk("async_rst_strobe", frame_strobe, 0);
        chk("async_rst_level", fifo_level, 0);
        chk("async_rst_urun", underrun_count, 0);
        chk("async_rst_ready", sample_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;

        // Ramp 0,4,8,12 then starve
        push(4'd0, 1);
        push(4'd4, 1);
        push(4'd8, 1);
        push(4'd12, 1);
        next_frame(gap);
        chk("post_rst_gap", gap + 4, 32);
        chk("ramp_prime_audio", audio_out, 0);
        for (int i = 0; i < 4; i++) begin
            next_frame(gap);
            chk("ramp_audio", audio_out, exp_seq[i]);
        end
        next_frame(gap);
        chk("ramp_urun_hold", audio_out, 16384);
        chk("ramp_urun_cnt", underrun_count, 1);
        next_frame(gap);
        chk("ramp_urun_state_hold", audio_out, 16384);
        next_frame(gap);
        chk("ramp_idle", audio_out, 0);

        // Fill to full with valid held, then mute one frame
        sample_in    = 4'd15;
        sample_valid = 1'b1;
        repeat (8) tick();
        chk("full_level", fifo_level, 8);
        chk("full_ready", sample_ready, 0);
        next_frame(gap);
        chk("full_prime_level", fifo_level, 8);
        chk("full_prime_audio", audio_out, 0);
        next_frame(gap);
        chk("full_pop_audio", audio_out, 28672);
        chk("full_pop_level", fifo_level, 7);
        chk("full_pop_ready", sample_ready, 1);
        tick();
        chk("refill_level", fifo_level, 8);
        chk("refill_ready", sample_ready, 0);
        mute = 1'b1;
        next_frame(gap);
        chk("mute_audio", audio_out, 0);
        chk("mute_level", fifo_level, 7);
        sample_valid = 1'b0;
        mute         = 1'b0;
        next_frame(gap);
        chk("unmute_audio", audio_out, 28672);
        chk("unmute_level", fifo_level, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
